vscale_htif_pcr_responder: RTL and testbench

- Core-side end of the HTIF PCR request/response interface. Accepts host PCR read/write requests and returns one response per request.
- Owns the tohost and fromhost CSRs. A host read of tohost clears it.
- Exposes tohost and fromhost to the core CSR file through a simple write-port interface.
- Sits inside vscale_top between the HTIF pins and vscale_csr_file.

---
 rtl/vscale_htif_pcr_responder.sv | 111 +++++++++++
 tb/tb_vscale_htif_pcr_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vscale_htif_pcr_responder.sv
// Core-side HTIF PCR responder: owns the tohost/fromhost CSRs and answers one
// host read/write request with exactly one response.
module vscale_htif_pcr_responder #(
    parameter int unsigned           PCR_WIDTH      = 64,
    parameter int unsigned           ADDR_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] ADDR_TO_HOST   = ADDR_WIDTH'(12'h780),
    parameter logic [ADDR_WIDTH-1:0] ADDR_FROM_HOST = ADDR_WIDTH'(12'h781)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  htif_pcr_req_valid,
    output logic                  htif_pcr_req_ready,
    input  logic                  htif_pcr_req_rw,
    input  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
    input  logic [PCR_WIDTH-1:0]  htif_pcr_req_data,
    output logic                  htif_pcr_resp_valid,
    input  logic                  htif_pcr_resp_ready,
    output logic [PCR_WIDTH-1:0]  htif_pcr_resp_data,
    input  logic                  core_tohost_wen,
    input  logic [PCR_WIDTH-1:0]  core_tohost_wdata,
    input  logic                  core_fromhost_wen,
    input  logic [PCR_WIDTH-1:0]  core_fromhost_wdata,
    output logic [PCR_WIDTH-1:0]  tohost,
    output logic [PCR_WIDTH-1:0]  fromhost
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PCR_WIDTH-1:0]   tohost_q, tohost_d;
    logic [PCR_WIDTH-1:0]   fromhost_q, fromhost_d;
    logic [PCR_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                   accept;
    logic                   hit_to;
    logic                   hit_from;

    // Next-state, CSR update and response capture.
    always_comb begin
        state_d     = state_q;
        tohost_d    = tohost_q;
        fromhost_d  = fromhost_q;
        resp_data_d = resp_data_q;
        accept      = htif_pcr_req_valid && (state_q == IDLE);
        hit_to      = (htif_pcr_req_addr == ADDR_TO_HOST);
        hit_from    = (htif_pcr_req_addr == ADDR_FROM_HOST);

        // Core fromhost write first so a simultaneous host write overrides it.
        if (core_fromhost_wen) begin
            fromhost_d = core_fromhost_wdata;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RESP;
                    resp_data_d = '0;
                    if (htif_pcr_req_rw) begin
                        if (hit_to) begin
                            tohost_d = htif_pcr_req_data;
                        end
                        if (hit_from) begin
                            fromhost_d = htif_pcr_req_data;
                        end
                    end else begin
                        if (hit_to) begin
                            resp_data_d = tohost_q;
                            tohost_d    = '0;
                        end else if (hit_from) begin
                            resp_data_d = fromhost_q;
                        end
                    end
                end
            end
            RESP: begin
                if (htif_pcr_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Core tohost write beats any host access in the same cycle.
        if (core_tohost_wen) begin
            tohost_d = core_tohost_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tohost_q    <= '0;
            fromhost_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign htif_pcr_req_ready  = (state_q == IDLE);
    assign htif_pcr_resp_valid = (state_q == RESP);
    assign htif_pcr_resp_data  = resp_data_q;
    assign tohost              = tohost_q;
    assign fromhost            = fromhost_q;

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Bench for vscale_htif_pcr_responder: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_vscale_htif_pcr_responder;

    localparam int unsigned W  = 64;
    localparam int unsigned AW = 12;
    localparam logic [AW-1:0] A_TO   = 12'h780;
    localparam logic [AW-1:0] A_FROM = 12'h781;
    localparam logic [AW-1:0] A_OTH  = 12'h123;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_rw;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_data;
    logic          resp_valid, resp_ready;
    logic [W-1:0]  resp_data;
    logic          th_wen, fh_wen;
    logic [W-1:0]  th_wdata, fh_wdata;
    logic [W-1:0]  tohost, fromhost;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending-response flag, its payload, and the two CSRs.
    bit           m_busy;
    logic [W-1:0] m_resp, m_to, m_from;

    vscale_htif_pcr_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .core_tohost_wen     (th_wen),
        .core_tohost_wdata   (th_wdata),
        .core_fromhost_wen   (fh_wen),
        .core_fromhost_wdata (fh_wdata),
        .tohost              (tohost),
        .fromhost            (fromhost)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("req_ready", W'(req_ready), W'(!m_busy));
        check_eq("resp_valid", W'(resp_valid), W'(m_busy));
        if (m_busy) check_eq("resp_data", resp_data, m_resp);
        check_eq("tohost", tohost, m_to);
        check_eq("fromhost", fromhost, m_from);
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance the
    // model by the rules for that cycle, then check at the next falling edge.
    task automatic step(input bit v, input bit rw, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input bit rr,
                        input bit tw, input logic [W-1:0] twd,
                        input bit fw, input logic [W-1:0] fwd);
        logic [W-1:0] nt, nf;
        bit host_wr_from;
        req_valid = v;  req_rw = rw;  req_addr = a;  req_data = d;
        resp_ready = rr;
        th_wen = tw; th_wdata = twd; fh_wen = fw; fh_wdata = fwd;

        nt = m_to;
        nf = m_from;
        host_wr_from = 1'b0;
        if (m_busy) begin
            if (rr) m_busy = 1'b0;
        end else if (v) begin
            m_busy = 1'b1;
            if (!rw) begin
                m_resp = (a == A_TO) ? m_to : (a == A_FROM) ? m_from : '0;
                if (a == A_TO) nt = '0;
            end else begin
                m_resp = '0;
                if (a == A_TO) nt = d;
                if (a == A_FROM) begin
                    nf = d;
                    host_wr_from = 1'b1;
                end
            end
        end
        if (tw) nt = twd;
        if (fw && !host_wr_from) nf = fwd;
        m_to = nt;
        m_from = nf;

        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input bit rr);
        step(0, 0, '0, '0, rr, 0, '0, 0, '0);
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0; resp_ready = 0;
        th_wen = 0; th_wdata = '0; fh_wen = 0; fh_wdata = '0;
        m_busy = 0; m_resp = '0; m_to = '0; m_from = '0;

        @(negedge clk);
        check_eq("rst_resp_valid", W'(resp_valid), '0);
        check_eq("rst_resp_data", resp_data, '0);
        check_eq("rst_tohost", tohost, '0);
        check_eq("rst_fromhost", fromhost, '0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", W'(req_ready), W'(1));
        check_model();

        // Core writes tohost=144, host reads it, then polls again.
        step(0, 0, '0, '0, 1, 1, 64'd144, 0, '0);
        step(1, 0, A_TO, '0, 1, 0, '0, 0, '0);
        check_eq("rd144_valid", W'(resp_valid), W'(1));
        check_eq("rd144_data", resp_data, 64'd144);
        idle(1);
        check_eq("rd144_cleared", tohost, '0);
        step(1, 0, A_TO, '0, 1, 0, '0, 0, '0);
        check_eq("poll_zero", resp_data, '0);
        idle(1);

        // Host writes fromhost, core clears it, host reads it back.
        step(1, 1, A_FROM, 64'h5, 1, 0, '0, 0, '0);
        check_eq("wr_from_resp", resp_data, '0);
        idle(1);
        check_eq("fromhost_5", fromhost, 64'h5);
        step(0, 0, '0, '0, 1, 0, '0, 1, '0);
        step(1, 0, A_FROM, '0, 1, 0, '0, 0, '0);
        check_eq("rd_from_zero", resp_data, '0);
        idle(1);

        // Backpressure: response of 7 held for 3 cycles.
        step(0, 0, '0, '0, 0, 1, 64'd7, 0, '0);
        step(1, 0, A_TO, '0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, A_FROM, '0, 0, 0, '0, 0, '0);
            check_eq("stall_data", resp_data, 64'd7);
            check_eq("stall_ready", W'(req_ready), '0);
        end
        idle(1);
        check_eq("release_ready", W'(req_ready), W'(1));

        // Read-clear collides with core tohost write.
        step(0, 0, '0, '0, 1, 1, 64'd3, 0, '0);
        step(1, 0, A_TO, '0, 1, 1, 64'd9, 0, '0);
        check_eq("coll_resp", resp_data, 64'd3);
        check_eq("coll_tohost", tohost, 64'd9);
        idle(1);

        // Host write of fromhost wins over core fromhost write.
        step(1, 1, A_FROM, 64'hAA, 1, 0, '0, 1, 64'hBB);
        check_eq("from_host_wins", fromhost, 64'hAA);
        idle(1);

        // Unmapped address.
        step(1, 0, A_OTH, '0, 1, 0, '0, 0, '0);
        check_eq("oth_rd", resp_data, '0);
        idle(1);
        step(1, 1, A_OTH, 64'hDEAD, 1, 0, '0, 0, '0);
        check_eq("oth_wr_valid", W'(resp_valid), W'(1));
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            int sel;
            sel = int'($urandom_range(0, 3));
            a = (sel == 0) ? A_TO : (sel == 1) ? A_FROM : (sel == 2) ? A_OTH : AW'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                 {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 4) == 0, {$urandom, $urandom},
                 $urandom_range(0, 4) == 0, {$urandom, $urandom});
        end

        // Reset asserted while a response is pending.
        idle(1);
        idle(1);
        step(1, 0, A_FROM, '0, 0, 0, '0, 0, '0);
        check_eq("pre_rst_valid", W'(resp_valid), W'(1));
        reset = 1'b0;
        #1;
        check_eq("async_rst_valid", W'(resp_valid), '0);
        check_eq("async_rst_tohost", tohost, '0);
        m_busy = 0; m_resp = '0; m_to = '0; m_from = '0;
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
